// File: rtl/frame_tx_if.sv
// frame_tx request/ack handshake bundle.
// The master offers a payload word; the slave reports accept, busy and done.
interface frame_tx_if;
   logic [31:0] din_tx;
   logic        req_tx;
   logic        ack_tx;
   logic        busy_tx;
   logic        done_tx;

   modport master (
      output din_tx,
      output req_tx,
      input  ack_tx,
      input  busy_tx,
      input  done_tx
   );

   modport slave (
      input  din_tx,
      input  req_tx,
      output ack_tx,
      output busy_tx,
      output done_tx
   );
endinterface

// File: rtl/frame_tx.sv
// Frame transmitter: 4 header bytes plus a 32-bit payload, big-endian.
// Every byte goes out as UART 8N1 on txd, BAUD_DIV clocks per bit.
module frame_tx #(
   parameter int unsigned BAUD_DIV = 16,
   parameter logic [7:0]  H1       = 8'hC4,
   parameter logic [7:0]  H2       = 8'hC9,
   parameter logic [7:0]  H3       = 8'hCC,
   parameter logic [7:0]  H4       = 8'hD2
) (
   input  logic       clk,
   input  logic       rst,
   frame_tx_if.slave  bus,
   output logic       txd
);

   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [3:0]      bit_q, bit_d;
   logic [2:0]      byte_q, byte_d;
   logic [31:0]     shreg_q, shreg_d;
   logic            txd_q, txd_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [7:0]      cur_byte;

   always_comb begin
      cur_byte = H1;
      unique case (byte_q)
         3'd0: cur_byte = H1;
         3'd1: cur_byte = H2;
         3'd2: cur_byte = H3;
         3'd3: cur_byte = H4;
         3'd4: cur_byte = shreg_q[31:24];
         3'd5: cur_byte = shreg_q[23:16];
         3'd6: cur_byte = shreg_q[15:8];
         3'd7: cur_byte = shreg_q[7:0];
      endcase
   end

   // txd_d is the line level for the cycle after this edge
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (bus.req_tx) begin
               shreg_d = bus.din_tx;
               ack_d   = 1'b1;
               busy_d  = 1'b1;
               txd_d   = 1'b0;
               state_d = SEND;
               baud_d  = '0;
               bit_d   = 4'd0;
               byte_d  = 3'd0;
            end
         end
         SEND: begin
            if (baud_q != BAUD_LAST) begin
               baud_d = baud_q + 1'b1;
            end else begin
               baud_d = '0;
               if (bit_q == 4'd9) begin
                  bit_d = 4'd0;
                  if (byte_q == 3'd7) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     txd_d   = 1'b1;
                     byte_d  = 3'd0;
                  end else begin
                     byte_d = byte_q + 3'd1;
                     txd_d  = 1'b0;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  txd_d = (bit_q < 4'd8) ? cur_byte[bit_q[2:0]] : 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 4'd0;
         byte_q  <= 3'd0;
         shreg_q <= 32'd0;
         txd_q   <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.ack_tx  = ack_q;
   assign bus.busy_tx = busy_q;
   assign bus.done_tx = done_q;
   assign txd         = txd_q;

endmodule

// File: tb/tb_frame_tx.sv
// Bench for frame_tx: two instances (BAUD_DIV 16 and 4) checked
// against a byte/bit-level model of the 8N1 frame.
module tb_frame_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] din = 32'd0;
   logic        sel = 1'b0;
   logic        txd_a, txd_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   frame_tx_if ia ();
   frame_tx_if ib ();

   assign ia.din_tx = din;
   assign ib.din_tx = din;
   assign ia.req_tx = req & ~sel;
   assign ib.req_tx = req & sel;

   frame_tx #(.BAUD_DIV(16)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ia),
      .txd (txd_a)
   );

   frame_tx #(.BAUD_DIV(4)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ib),
      .txd (txd_b)
   );

   wire txd  = sel ? txd_b      : txd_a;
   wire ack  = sel ? ib.ack_tx  : ia.ack_tx;
   wire busy = sel ? ib.busy_tx : ia.busy_tx;
   wire done = sel ? ib.done_tx : ia.done_tx;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Frame model: byte b, position p: p=0 start, p=9 stop, else data LSB first
   function automatic logic model_bit(input logic [31:0] w, input int k);
      logic [7:0] fb [8];
      logic [7:0] by;
      int         p;
      fb[0] = 8'hC4; fb[1] = 8'hC9; fb[2] = 8'hCC; fb[3] = 8'hD2;
      fb[4] = w[31:24]; fb[5] = w[23:16]; fb[6] = w[15:8]; fb[7] = w[7:0];
      by = fb[k / 10];
      p  = k % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return by[p - 1];
   endfunction

   function automatic logic [7:0] model_byte(input logic [31:0] w, input int b);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < 8; i++) r[i] = model_bit(w, b * 10 + 1 + i);
      return r;
   endfunction

   task automatic run_frame(input string nm, input logic [31:0] w, input int div,
                            input bit acked, input int pulse_at,
                            input int rst_at, input bit hold,
                            input logic [31:0] nw);
      int         hold_err;
      int         busy_err;
      int         extra_ack;
      int         done_err;
      int         k;
      logic       eb;
      logic [79:0] samp;
      logic [7:0] rb;
      hold_err = 0; busy_err = 0; extra_ack = 0; done_err = 0;
      samp = '0;
      if (!acked) begin
         din = w;
         req = 1'b1;
         @(posedge clk); #1;
         chk({nm, "_ack"}, {31'd0, ack}, 32'd1);
      end
      if (!hold) req = 1'b0;
      for (int c = 0; c < 80 * div; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         k  = c / div;
         eb = model_bit(w, k);
         if (txd !== eb) hold_err++;
         if (c % div == div / 2) begin
            samp[k] = txd;
            if (k < 10 || k >= 40)
               chk($sformatf("%s_bit%0d", nm, k), {31'd0, txd}, {31'd0, eb});
         end
         if (busy !== 1'b1) busy_err++;
         if (c > 0 && ack !== 1'b0) extra_ack++;
         if (done !== 1'b0) done_err++;
         if (c == 0) din = ~w;
         if (c == pulse_at) begin
            req = 1'b1;
            din = 32'hDEADBEEF;
         end
         if (c == pulse_at + 1 && !hold) req = 1'b0;
         if (hold && c == 80 * div - 1) din = nw;
         if (c == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk({nm, "_rst_txd"}, {31'd0, txd}, 32'd1);
            chk({nm, "_rst_busy"}, {31'd0, busy}, 32'd0);
            done_err = 0;
            for (int j = 0; j < 20 * div; j++) begin
               @(posedge clk); #1;
               if (done !== 1'b0 || txd !== 1'b1) done_err++;
            end
            chk({nm, "_rst_quiet"}, done_err, 0);
            return;
         end
      end
      chk({nm, "_hold"}, hold_err, 0);
      chk({nm, "_busy"}, busy_err, 0);
      chk({nm, "_noack"}, extra_ack, 0);
      chk({nm, "_early_done"}, done_err, 0);
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 8; i++) rb[i] = samp[b * 10 + 1 + i];
         chk($sformatf("%s_byte%0d", nm, b), {24'd0, rb},
             {24'd0, model_byte(w, b)});
      end
      @(posedge clk); #1;
      chk({nm, "_done"}, {31'd0, done}, 32'd1);
      chk({nm, "_done_ack"}, {31'd0, ack}, 32'd0);
      chk({nm, "_done_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done_txd"}, {31'd0, txd}, 32'd1);
      if (hold) begin
         @(posedge clk); #1;
         chk({nm, "_b2b_ack"}, {31'd0, ack}, 32'd1);
      end else begin
         @(posedge clk); #1;
         chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] rw;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", {31'd0, txd_a}, 32'd1);
      chk("rst_ack", {31'd0, ia.ack_tx}, 32'd0);
      chk("rst_busy", {31'd0, ia.busy_tx}, 32'd0);
      chk("rst_done", {31'd0, ia.done_tx}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      sel = 1'b0;
      run_frame("f1", 32'h12345678, 16, 1'b0, 300, -1, 1'b0, 32'd0);
      run_frame("f2", 32'hDEADBEEF, 16, 1'b0, -1, -1, 1'b1, 32'h0BADF00D);
      run_frame("f3", 32'h0BADF00D, 16, 1'b1, -1, 820, 1'b0, 32'd0);
      run_frame("f4", 32'hA5A55A5A, 16, 1'b0, -1, -1, 1'b0, 32'd0);
      run_frame("f5", 32'h89ABCDEF, 16, 1'b0, -1, -1, 1'b0, 32'd0);

      sel = 1'b1;
      @(posedge clk); #1;
      run_frame("d4", 32'h00000000, 4, 1'b0, -1, -1, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         rw = $urandom;
         run_frame($sformatf("r4_%0d", i), rw, 4, 1'b0,
                   $urandom_range(1, 300), -1, 1'b0, 32'd0);
      end
      sel = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         rw = $urandom;
         run_frame($sformatf("r16_%0d", i), rw, 16, 1'b0,
                   $urandom_range(1, 1200), -1, 1'b0, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_tx.md
Name: frame_tx

Overview:
- Transmit-side counterpart of the receive path's header scanner (SCAN) and UART receiver (rx).
- Takes one 32-bit word per req/ack handshake and wraps it in a 4-byte header (C4 C9 CC D2), giving 8 bytes per frame.
- Serialises all 8 bytes as UART 8N1 on txd.
- Runs on the divided tick clock (tclk, 16x baud). Its output is the frame SCAN on the far end re-assembles.

Parameters:
- BAUD_DIV, 16: clk cycles per UART bit, legal range 2..255.
- H1, 8'hC4: header byte 1, sent first.
- H2, 8'hC9: header byte 2.
- H3, 8'hCC: header byte 3.
- H4, 8'hD2: header byte 4.

Ports:
- clk  input  1  tick clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- din_tx  input  32  payload word, sampled only on the accept edge.
- req_tx  input  1  level request to send din_tx.
- ack_tx  output  1  one-cycle pulse: payload latched, frame started.
- busy_tx  output  1  high from the accept edge to the end of the frame.
- done_tx  output  1  one-cycle pulse after the last stop bit completes.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset values:
  - txd=1, ack_tx=0, busy_tx=0, done_tx=0.
  - State IDLE; bit counter, byte counter and baud counter all 0.
  - Reset is synchronous, so it takes effect at the next edge.
- Reset mid-frame: abort immediately. txd=1 and state IDLE at the next edge; no done_tx pulse.
- State IDLE:
  - txd=1, busy_tx=0.
  - On an edge with req_tx=1:
    - Latch din_tx into a shift register.
    - ack_tx<=1 for one cycle and busy_tx<=1.
    - txd<=0 (start bit of byte 0) and go to SEND.
    - The start bit therefore begins in the same cycle ack_tx is high.
- State SEND, byte sequence (index 0..7): H1, H2, H3, H4, din[31:24], din[23:16], din[15:8], din[7:0].
- Per byte:
  - Send 10 bits: start(0), d0..d7 (LSB first), stop(1).
  - Each bit holds exactly BAUD_DIV cycles, counted by the baud counter 0..BAUD_DIV-1.
  - No gap between bytes: the next start bit begins the cycle after the previous stop bit's last cycle.
- End of frame:
  - On the edge ending the stop bit of byte 7: state<=IDLE, busy_tx<=0, done_tx<=1 for one cycle, txd stays 1.
  - Frame length is exactly 80*BAUD_DIV cycles, measured from the ack_tx cycle to the last stop-bit cycle inclusive.
- req_tx while busy_tx=1 is ignored: no ack, no queueing.
- A still-asserted req_tx is evaluated in IDLE.
- Back-to-back frames:
  - req_tx held high makes the next ack_tx occur in the cycle after done_tx.
  - That extends the last stop bit to BAUD_DIV+1 cycles, which is legal for 8N1.
- din_tx changes after the accept edge have no effect on the frame in progress.
- Counter widths: baud counter is ceil(log2(BAUD_DIV)) bits, bit counter 4 bits, byte counter 3 bits. No wrap-around except at defined terminal counts.
- ack_tx and done_tx are never high in the same cycle.

Test Plan:
- Single frame:
  - Stimulus: rst, then req_tx=1 for 1 cycle with din_tx=32'h12345678, BAUD_DIV=16.
  - Response: the decoded line carries bytes C4 C9 CC D2 12 34 56 78.
  - Response: done_tx arrives exactly 1280 cycles after ack_tx.
  - Response: busy_tx is high for the whole 1280 cycles.
- Bit waveform of byte 0:
  - Sample txd mid-bit every 16 cycles.
  - Expected: 0 | 0 0 1 0 0 0 1 1 | 1, i.e. start, C4 LSB first, stop.
  - Each level is held exactly 16 cycles.
- Request during busy:
  - Pulse req_tx at cycle 300 with din_tx=32'hDEADBEEF; change din_tx after the first ack.
  - Response: no second ack; payload bytes still 12 34 56 78.
  - Response: after done_tx, a held req_tx produces ack_tx exactly 1 cycle later.
- Reset mid-frame:
  - Assert rst during byte 5.
  - Response: txd=1 and busy_tx=0 at the next edge; no done_tx pulse.
  - Response: a following req_tx with 32'hA5A55A5A sends a complete correct frame.
- Parameter variant: BAUD_DIV=4, din_tx=32'h00000000.
  - Response: frame is 320 cycles; payload bits all 0; every stop bit is 1.
- Loopback:
  - Connect txd to the rx/SCAN receive path, all blocks on the same tclk.
  - Send 32'h89ABCDEF.
  - Response: receiver flag_rx asserts with din_rx=32'h89ABCDEF.
